x_lut6_cfg_loader: RTL and testbench
====================================

Name: x_lut6_cfg_loader

Overview:
- Upstream feeder for a run-time reconfigurable LUT6 evaluation stage.
- Receives a 64-bit truth table as a byte stream over a valid/ready handshake and assembles it in a shadow register.
- On COMMIT, atomically transfers the shadow table to the active TABLE output, which drives the downstream LUT's INIT/truth-table input (O = TABLE[{ADR5..ADR0}]).
- Double-buffered, so the downstream LUT never sees a partially loaded table.

Parameters:
- INIT, 64'h0000000000000000, active TABLE value after reset.
- MSB_FIRST, 0; byte order. 0: first byte lands in TABLE[7:0]. 1: first byte lands in TABLE[63:56].

Ports:
- CLK  input  1  clock; all state updates on its rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- CFG_VALID  input  1  CFG_DATA/CFG_LAST valid this cycle.
- CFG_READY  output  1  loader can accept a byte this cycle.
- CFG_DATA  input  8  truth-table byte.
- CFG_LAST  input  1  marks the final (8th) byte of a table.
- COMMIT  input  1  single-cycle pulse: promote shadow to active.
- ABORT  input  1  single-cycle pulse: discard the load in progress.
- ERR_CLR  input  1  clears ERR.
- TABLE  output  64  active truth table feeding the LUT.
- SHADOW_FULL  output  1  complete, valid table waiting for COMMIT.
- BUSY  output  1  partial load in progress (1..7 bytes accepted).
- ERR  output  1  sticky framing error.
- COMMIT_CNT  output  8  number of successful commits, wraps 255->0.

Behaviour:
- Reset (RST_N=0, takes effect immediately):
  - TABLE=INIT, shadow=0, byte count=0, state=IDLE.
  - CFG_READY=1 once RST_N deasserts; SHADOW_FULL=0, BUSY=0, ERR=0, COMMIT_CNT=0.
  - Reset mid-load discards the shadow; TABLE returns to INIT.
- Handshake: a byte is accepted on a CLK edge where CFG_VALID & CFG_READY. CFG_READY=1 in IDLE and LOAD, 0 in FULL. CFG_READY does not depend combinationally on CFG_VALID.
- FSM states: IDLE, LOAD, FULL.
  - IDLE, byte accepted: count becomes 1, go to LOAD.
  - LOAD: each accepted byte increments count.
  - Byte index k (0..7) is written to shadow[8k+7:8k] when MSB_FIRST=0, or shadow[63-8k:56-8k] when MSB_FIRST=1.
  - Accepted byte with CFG_LAST=1 and k=7: go to FULL, SHADOW_FULL=1 on the next cycle.
  - CFG_LAST=1 with k<7 (early last): ERR<=1, count<=0, go to IDLE; shadow content is don't-care.
  - k=7 with CFG_LAST=0 (missing last): same as early last, ERR<=1, go to IDLE.
  - FULL, COMMIT=1: TABLE<=shadow on that edge (visible the next cycle), COMMIT_CNT+1, go to IDLE, SHADOW_FULL<=0.
  - COMMIT in IDLE or LOAD is ignored; TABLE and COMMIT_CNT are unchanged.
- ABORT, in any state: go to IDLE, count=0, SHADOW_FULL=0.
  - ABORT has priority over COMMIT and over a simultaneous byte accept; that byte is dropped.
  - ABORT does not set ERR.
- ERR: sticky. ERR_CLR clears it the next cycle. If ERR_CLR coincides with a new error, set wins.
- BUSY = (state==LOAD).
- TABLE changes only on a successful commit or reset, and all 64 bits update on one edge.
- Latency: last byte accepted to SHADOW_FULL is 1 cycle; COMMIT to new TABLE is 1 cycle. Minimum load is 8 cycles.

Decomposition:
- Shared package x_lut_cfg_pkg contains:
  - state enum {IDLE, LOAD, FULL};
  - constants LUT_BITS=64, CFG_BYTES=8, BYTE_W=8.
- No sub-module; a single module of roughly 150-200 lines. The downstream LUT evaluation stage instantiates this block and indexes TABLE.

Test Plan:
- Reset with INIT=64'hDEADBEEF_01234567 -> TABLE=64'hDEADBEEF01234567, CFG_READY=1, COMMIT_CNT=0, ERR=0.
- MSB_FIRST=0, bytes 01,02..08 with LAST on the 8th, then COMMIT -> TABLE=64'h0807060504030201 one cycle after COMMIT, COMMIT_CNT=1. Repeat with MSB_FIRST=1 -> TABLE=64'h0102030405060708.
- CFG_LAST on the 3rd byte -> ERR=1, BUSY=0; a subsequent COMMIT leaves TABLE unchanged; ERR_CLR -> ERR=0.
- Full 8-byte load (SHADOW_FULL=1) with CFG_VALID held high -> CFG_READY=0, no byte accepted; then COMMIT and ABORT asserted in the same cycle -> TABLE unchanged, SHADOW_FULL=0, COMMIT_CNT unchanged.
- RST_N pulled low after 5 bytes -> BUSY=0 and TABLE=INIT immediately; a fresh 8-byte load then commits normally.
- 256 back-to-back successful commits -> COMMIT_CNT wraps to 0; TABLE equals the last committed value.

Source files
------------

// File: rtl/x_lut_cfg_pkg.sv
// Shared definitions for the LUT6 truth-table configuration loader.
package x_lut_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } cfg_state_e;

  localparam int LUT_BITS  = 64;
  localparam int CFG_BYTES = 8;
  localparam int BYTE_W    = 8;

  // Low bit position of byte k inside the 64-bit table.
  // In MSB-first order byte k lands at 8*(7-k), and 7-k is the bitwise
  // complement of a 3-bit k.
  function automatic logic [5:0] byte_lo(input logic [2:0] k, input logic msb_first);
    logic [5:0] lo;
    if (msb_first) begin
      lo = {~k, 3'b000};
    end else begin
      lo = {k, 3'b000};
    end
    return lo;
  endfunction

endpackage

// File: rtl/x_lut6_cfg_loader.sv
// Byte-stream loader for a run-time reconfigurable LUT6 truth table.
// Bytes are assembled in a shadow register; COMMIT promotes the complete
// shadow table to TABLE in a single edge so the downstream LUT never sees
// a partially written table.
module x_lut6_cfg_loader
  import x_lut_cfg_pkg::*;
#(
  parameter logic [63:0] INIT      = 64'h0000000000000000,
  parameter logic        MSB_FIRST = 1'b0
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CFG_VALID,
  output logic        CFG_READY,
  input  logic [7:0]  CFG_DATA,
  input  logic        CFG_LAST,
  input  logic        COMMIT,
  input  logic        ABORT,
  input  logic        ERR_CLR,
  output logic [63:0] TABLE,
  output logic        SHADOW_FULL,
  output logic        BUSY,
  output logic        ERR,
  output logic [7:0]  COMMIT_CNT
);

  cfg_state_e  state_r;
  logic [2:0]  byte_idx_r;
  logic [63:0] shadow_r;
  logic [63:0] table_r;
  logic        ready_r;
  logic        full_r;
  logic        busy_r;
  logic        err_r;
  logic [7:0]  commit_cnt_r;

  logic        accept_s;
  logic        last_pos_s;

  // A byte moves on any edge where the source offers it and we are not holding a full table.
  assign accept_s   = CFG_VALID & ready_r;
  assign last_pos_s = (byte_idx_r == 3'd7);

  // Load/commit FSM with all status outputs registered alongside the state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r      <= IDLE;
      byte_idx_r   <= 3'd0;
      shadow_r     <= 64'h0000000000000000;
      table_r      <= INIT;
      ready_r      <= 1'b1;
      full_r       <= 1'b0;
      busy_r       <= 1'b0;
      err_r        <= 1'b0;
      commit_cnt_r <= 8'd0;
    end else begin
      // Clear first; a framing error detected below on the same edge overrides it.
      if (ERR_CLR) begin
        err_r <= 1'b0;
      end

      if (ABORT) begin
        // Abort outranks commit and any byte offered this cycle.
        state_r    <= IDLE;
        byte_idx_r <= 3'd0;
        full_r     <= 1'b0;
        busy_r     <= 1'b0;
        ready_r    <= 1'b1;
      end else begin
        case (state_r)
          IDLE, LOAD: begin
            if (accept_s) begin
              shadow_r[byte_lo(byte_idx_r, MSB_FIRST) +: BYTE_W] <= CFG_DATA;
              if (CFG_LAST && last_pos_s) begin
                state_r    <= FULL;
                byte_idx_r <= 3'd0;
                full_r     <= 1'b1;
                busy_r     <= 1'b0;
                ready_r    <= 1'b0;
              end else if (CFG_LAST || last_pos_s) begin
                // Early LAST or missing LAST: framing error, drop the partial table.
                state_r    <= IDLE;
                byte_idx_r <= 3'd0;
                busy_r     <= 1'b0;
                err_r      <= 1'b1;
              end else begin
                state_r    <= LOAD;
                byte_idx_r <= byte_idx_r + 3'd1;
                busy_r     <= 1'b1;
              end
            end
          end
          FULL: begin
            if (COMMIT) begin
              table_r      <= shadow_r;
              commit_cnt_r <= commit_cnt_r + 8'd1;
              state_r      <= IDLE;
              full_r       <= 1'b0;
              ready_r      <= 1'b1;
            end
          end
          default: begin
            state_r    <= IDLE;
            byte_idx_r <= 3'd0;
            full_r     <= 1'b0;
            busy_r     <= 1'b0;
            ready_r    <= 1'b1;
          end
        endcase
      end
    end
  end

  assign CFG_READY   = ready_r;
  assign TABLE       = table_r;
  assign SHADOW_FULL = full_r;
  assign BUSY        = busy_r;
  assign ERR         = err_r;
  assign COMMIT_CNT  = commit_cnt_r;

endmodule

// File: tb/tb_x_lut6_cfg_loader.sv
// Bench for x_lut6_cfg_loader: one LSB-first and one MSB-first instance
// share the same stimulus and are compared against a queue-based model.
module tb_x_lut6_cfg_loader;

  localparam logic [63:0] INIT_V = 64'hDEADBEEF01234567;
  localparam logic [63:0] L0     = 64'h0807060504030201;
  localparam logic [63:0] L1     = 64'h0102030405060708;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [7:0]  cfg_data = 8'h00;
  logic        cfg_last = 1'b0;
  logic        commit = 1'b0;
  logic        abort = 1'b0;
  logic        err_clr = 1'b0;

  logic        ready0, full0, busy0, err0;
  logic        ready1, full1, busy1, err1;
  logic [63:0] table0, table1;
  logic [7:0]  cnt0, cnt1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  x_lut6_cfg_loader #(.INIT(INIT_V), .MSB_FIRST(1'b0)) dut0 (
    .CLK(clk), .RST_N(rst_n), .CFG_VALID(cfg_valid), .CFG_READY(ready0),
    .CFG_DATA(cfg_data), .CFG_LAST(cfg_last), .COMMIT(commit), .ABORT(abort),
    .ERR_CLR(err_clr), .TABLE(table0), .SHADOW_FULL(full0), .BUSY(busy0),
    .ERR(err0), .COMMIT_CNT(cnt0)
  );

  x_lut6_cfg_loader #(.INIT(INIT_V), .MSB_FIRST(1'b1)) dut1 (
    .CLK(clk), .RST_N(rst_n), .CFG_VALID(cfg_valid), .CFG_READY(ready1),
    .CFG_DATA(cfg_data), .CFG_LAST(cfg_last), .COMMIT(commit), .ABORT(abort),
    .ERR_CLR(err_clr), .TABLE(table1), .SHADOW_FULL(full1), .BUSY(busy1),
    .ERR(err1), .COMMIT_CNT(cnt1)
  );

  // ---------------- reference model ----------------
  logic [7:0]  mq[$];
  bit          m_full, m_err;
  logic [63:0] m_t0, m_t1;
  logic [7:0]  m_cnt;

  function automatic logic [63:0] assemble(input bit msb);
    logic [63:0] t = 64'h0;
    for (int i = 0; i < 8; i++) begin
      t |= 64'(mq[i]) << (msb ? 8 * (7 - i) : 8 * i);
    end
    return t;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_full = 1'b0;
    m_err  = 1'b0;
    m_t0   = INIT_V;
    m_t1   = INIT_V;
    m_cnt  = 8'd0;
  endtask

  task automatic model_edge();
    bit set_err = 1'b0;
    if (abort) begin
      mq.delete();
      m_full = 1'b0;
    end else if (m_full) begin
      if (commit) begin
        m_t0 = assemble(1'b0);
        m_t1 = assemble(1'b1);
        m_cnt = m_cnt + 8'd1;
        mq.delete();
        m_full = 1'b0;
      end
    end else if (cfg_valid) begin
      mq.push_back(cfg_data);
      if (mq.size() == 8 && cfg_last) begin
        m_full = 1'b1;
      end else if (cfg_last || mq.size() == 8) begin
        set_err = 1'b1;
        mq.delete();
      end
    end
    if (err_clr) m_err = 1'b0;
    if (set_err) m_err = 1'b1;
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    bit exp_busy;
    exp_busy = !m_full && (mq.size() > 0);
    chk("model.table0", table0, m_t0);
    chk("model.table1", table1, m_t1);
    chk("model.ready0", 64'(ready0), 64'(!m_full));
    chk("model.ready1", 64'(ready1), 64'(!m_full));
    chk("model.full0",  64'(full0),  64'(m_full));
    chk("model.full1",  64'(full1),  64'(m_full));
    chk("model.busy0",  64'(busy0),  64'(exp_busy));
    chk("model.busy1",  64'(busy1),  64'(exp_busy));
    chk("model.err0",   64'(err0),   64'(m_err));
    chk("model.err1",   64'(err1),   64'(m_err));
    chk("model.cnt0",   64'(cnt0),   64'(m_cnt));
    chk("model.cnt1",   64'(cnt1),   64'(m_cnt));
  endtask

  // Drive one cycle of inputs, advance the model at the edge, compare on the falling edge.
  task automatic step(input logic v, input logic [7:0] d, input logic l,
                      input logic c, input logic a, input logic e);
    cfg_valid = v; cfg_data = d; cfg_last = l; commit = c; abort = a; err_clr = e;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cfg_valid = 1'b0; cfg_last = 1'b0; commit = 1'b0; abort = 1'b0; err_clr = 1'b0;
    model_reset();
    #1;
    chk("rst.table0", table0, INIT_V);
    chk("rst.table1", table1, INIT_V);
    chk("rst.cnt",    64'(cnt0), 64'd0);
    chk("rst.err",    64'(err0), 64'd0);
    chk("rst.busy",   64'(busy0), 64'd0);
    chk("rst.full",   64'(full0), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.ready0", 64'(ready0), 64'd1);
    chk("rst.ready1", 64'(ready1), 64'd1);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        l, c, a, e;
    logic [63:0] t0, t1;
    logic        full, busy, err;
    logic [7:0]  cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v, input logic [7:0] d, input logic l, input logic c,
                     input logic a, input logic e, input logic [63:0] t0, input logic [63:0] t1,
                     input logic full, input logic busy, input logic err, input logic [7:0] cnt);
    vec_t x;
    x.v = v; x.d = d; x.l = l; x.c = c; x.a = a; x.e = e;
    x.t0 = t0; x.t1 = t1; x.full = full; x.busy = busy; x.err = err; x.cnt = cnt;
    vecs.push_back(x);
  endtask

  initial begin
    logic [7:0] rd;

    // Basic load 01..08 with LAST on the 8th byte.
    for (int k = 1; k <= 7; k++)
      add(1'b1, 8'(k), 1'b0, 1'b0, 1'b0, 1'b0, INIT_V, INIT_V, 1'b0, 1'b1, 1'b0, 8'd0);
    add(1'b1, 8'h08, 1'b1, 1'b0, 1'b0, 1'b0, INIT_V, INIT_V, 1'b1, 1'b0, 1'b0, 8'd0);
    // VALID held while full: nothing accepted.
    add(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0, INIT_V, INIT_V, 1'b1, 1'b0, 1'b0, 8'd0);
    // Commit.
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, L0, L1, 1'b0, 1'b0, 1'b0, 8'd1);
    // Early LAST on the 3rd byte.
    add(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, L0, L1, 1'b0, 1'b1, 1'b0, 8'd1);
    add(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, L0, L1, 1'b0, 1'b1, 1'b0, 8'd1);
    add(1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0, L0, L1, 1'b0, 1'b0, 1'b1, 8'd1);
    // Commit while idle is ignored.
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, L0, L1, 1'b0, 1'b0, 1'b1, 8'd1);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, L0, L1, 1'b0, 1'b0, 1'b0, 8'd1);
    // Full load, then COMMIT+ABORT together: abort wins.
    for (int k = 0; k < 7; k++)
      add(1'b1, 8'hA0 + 8'(k), 1'b0, 1'b0, 1'b0, 1'b0, L0, L1, 1'b0, 1'b1, 1'b0, 8'd1);
    add(1'b1, 8'hA7, 1'b1, 1'b0, 1'b0, 1'b0, L0, L1, 1'b1, 1'b0, 1'b0, 8'd1);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, L0, L1, 1'b0, 1'b0, 1'b0, 8'd1);
    // Abort with a simultaneous byte: byte dropped.
    add(1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0, L0, L1, 1'b0, 1'b0, 1'b0, 8'd1);
    // Missing LAST on the 8th byte.
    for (int k = 0; k < 7; k++)
      add(1'b1, 8'hB0 + 8'(k), 1'b0, 1'b0, 1'b0, 1'b0, L0, L1, 1'b0, 1'b1, 1'b0, 8'd1);
    add(1'b1, 8'hB7, 1'b0, 1'b0, 1'b0, 1'b0, L0, L1, 1'b0, 1'b0, 1'b1, 8'd1);
    // ERR_CLR with a new error on the same edge: set wins.
    add(1'b1, 8'hC0, 1'b1, 1'b0, 1'b0, 1'b1, L0, L1, 1'b0, 1'b0, 1'b1, 8'd1);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, L0, L1, 1'b0, 1'b0, 1'b0, 8'd1);

    do_reset();

    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].c, vecs[i].a, vecs[i].e);
      chk($sformatf("vec%0d.table0", i), table0, vecs[i].t0);
      chk($sformatf("vec%0d.table1", i), table1, vecs[i].t1);
      chk($sformatf("vec%0d.full", i),  64'(full0), 64'(vecs[i].full));
      chk($sformatf("vec%0d.ready", i), 64'(ready0), 64'(!vecs[i].full));
      chk($sformatf("vec%0d.busy", i),  64'(busy0), 64'(vecs[i].busy));
      chk($sformatf("vec%0d.err", i),   64'(err0), 64'(vecs[i].err));
      chk($sformatf("vec%0d.cnt", i),   64'(cnt0), 64'(vecs[i].cnt));
    end

    // Reset pulled low after 5 bytes: takes effect without a clock edge.
    for (int k = 0; k < 5; k++) step(1'b1, 8'h70 + 8'(k), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("midrst.busy_before", 64'(busy0), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst.busy",   64'(busy0), 64'd0);
    chk("midrst.table0", table0, INIT_V);
    chk("midrst.table1", table1, INIT_V);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) step(1'b1, 8'(k), (k == 8), 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("midrst.reload0", table0, L0);
    chk("midrst.reload1", table1, L1);
    chk("midrst.cnt",     64'(cnt0), 64'd1);

    // Randomised traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic v, l, c, a, e;
      v  = ($urandom % 4) != 0;
      rd = 8'($urandom);
      l  = (mq.size() == 7) ? (($urandom % 8) != 0) : (($urandom % 16) == 0);
      c  = ($urandom % 3) == 0;
      a  = ($urandom % 40) == 0;
      e  = ($urandom % 10) == 0;
      step(v, rd, l, c, a, e);
    end

    // 256 back-to-back commits wrap the counter to zero.
    do_reset();
    for (int n = 0; n < 256; n++) begin
      for (int k = 0; k < 8; k++) begin
        rd = 8'($urandom);
        step(1'b1, rd, (k == 7), 1'b0, 1'b0, 1'b0);
      end
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    chk("wrap.cnt0",   64'(cnt0), 64'd0);
    chk("wrap.cnt1",   64'(cnt1), 64'd0);
    chk("wrap.table0", table0, m_t0);
    chk("wrap.table1", table1, m_t1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
